// File: rtl/oam_dma_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl_pkg
//  Description : State encoding and default register addresses for the
//                sprite (OAM) DMA controller.
//  Revision    : 1.0  initial release
// ============================================================================
package oam_dma_ctrl_pkg;

  localparam int          c_addr_n        = 16;
  localparam int          c_data_n        = 8;
  localparam logic [15:0] c_dma_reg_addr  = 16'h4014;
  localparam logic [15:0] c_oam_data_addr = 16'h2004;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

endpackage : oam_dma_ctrl_pkg
`default_nettype wire

// File: rtl/oam_dma_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : oam_dma_ctrl
//  Description : OAM DMA engine and bus master mux; halts the CPU and copies
//                one 256-byte page to the PPU OAM data port on get/put cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module oam_dma_ctrl
  import oam_dma_ctrl_pkg::*;
#(
  parameter int                ADDR_N        = c_addr_n,
  parameter int                DATA_N        = c_data_n,
  parameter logic [ADDR_N-1:0] DMA_REG_ADDR  = c_dma_reg_addr,
  parameter logic [ADDR_N-1:0] OAM_DATA_ADDR = c_oam_data_addr
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_we,
  input  logic [ADDR_N-1:0] cpu_addr,
  input  logic [DATA_N-1:0] cpu_wdata,
  output logic              cpu_rdy,
  output logic              bus_we,
  output logic [ADDR_N-1:0] bus_addr,
  output logic [DATA_N-1:0] bus_wdata,
  input  logic [DATA_N-1:0] bus_rdata,
  output logic              dma_busy
);

  dma_state_t        r_state;
  dma_state_t        w_next_state;
  logic [7:0]        r_page;
  logic [7:0]        r_cnt;
  logic [DATA_N-1:0] r_latch;
  logic              r_parity;
  logic              w_trigger;

  assign w_trigger = cpu_we && (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_page   <= 8'h00;
      r_cnt    <= 8'h00;
      r_latch  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_state  <= w_next_state;
      r_parity <= ~r_parity;
      if (r_state == IDLE && w_trigger) begin
        r_page <= cpu_wdata[7:0];
        r_cnt  <= 8'h00;
      end
      if (r_state == READ) begin
        r_latch <= bus_rdata;
      end
      if (r_state == WRITE) begin
        r_cnt <= r_cnt + 8'd1;
      end
    end
  end

  // HALT with parity 1 means the following cycle is a get cycle, so no ALIGN.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_trigger) w_next_state = HALT;
      HALT:    w_next_state = r_parity ? READ : ALIGN;
      ALIGN:   w_next_state = READ;
      READ:    w_next_state = WRITE;
      WRITE:   w_next_state = (r_cnt == 8'hFF) ? IDLE : READ;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    cpu_rdy   = 1'b0;
    dma_busy  = 1'b1;
    bus_we    = cpu_we;
    bus_addr  = cpu_addr;
    bus_wdata = cpu_wdata;
    case (r_state)
      IDLE: begin
        cpu_rdy  = 1'b1;
        dma_busy = 1'b0;
      end
      HALT, ALIGN: begin
        bus_we = 1'b0;
      end
      READ: begin
        bus_we   = 1'b0;
        bus_addr = ADDR_N'({r_page, r_cnt});
      end
      WRITE: begin
        bus_we    = 1'b1;
        bus_addr  = OAM_DATA_ADDR;
        bus_wdata = r_latch;
      end
      default: ;
    endcase
  end

endmodule : oam_dma_ctrl
`default_nettype wire
